horse_race_lamp: RTL and testbench



---
 rtl/horse_race_lamp_pkg.sv | 58 +++++
 rtl/lamp_step_div.sv | 30 +++
 rtl/horse_race_lamp.sv | 58 +++++
 tb/tb_horse_race_lamp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/horse_race_lamp_pkg.sv
// Shared mode encodings, pattern lengths and frame lookup for the running-lamp generator.
// Used by horse_race_lamp and lamp_step_div.
package horse_race_lamp_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT     = 2'b00,
        MODE_RIGHT    = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_FLASH    = 2'b11
    } mode_e;

    localparam int STEP_W = 3;
    typedef logic [STEP_W-1:0] step_t;

    localparam int LEN_LEFT     = 8;
    localparam int LEN_RIGHT    = 8;
    localparam int LEN_PINGPONG = 6;
    localparam int LEN_FLASH    = 2;

    function automatic step_t pattern_last(input mode_e mode);
        step_t last;
        case (mode)
            MODE_LEFT:     last = step_t'(LEN_LEFT - 1);
            MODE_RIGHT:    last = step_t'(LEN_RIGHT - 1);
            MODE_PINGPONG: last = step_t'(LEN_PINGPONG - 1);
            default:       last = step_t'(LEN_FLASH - 1);
        endcase
        return last;
    endfunction

    // Steps wrap at the pattern's own length so short patterns never reach 8.
    function automatic step_t next_step(input mode_e mode, input step_t step);
        return (step == pattern_last(mode)) ? '0 : step + step_t'(1);
    endfunction

    function automatic logic [7:0] frame_lookup(input mode_e mode, input step_t step);
        logic [7:0] frame;
        frame = 8'h01;
        case (mode)
            MODE_LEFT:  frame = 8'h01 << step;
            MODE_RIGHT: frame = 8'h80 >> step;
            MODE_PINGPONG: begin
                case (step)
                    3'd0:    frame = 8'h81;
                    3'd1:    frame = 8'h42;
                    3'd2:    frame = 8'h24;
                    3'd3:    frame = 8'h18;
                    3'd4:    frame = 8'h24;
                    3'd5:    frame = 8'h42;
                    default: frame = 8'h81;
                endcase
            end
            default: frame = step[0] ? 8'hAA : 8'h55;
        endcase
        return frame;
    endfunction

endpackage

// File: rtl/lamp_step_div.sv
// Clock-enable divider: tick is high for one clock every DIV_CYCLES clocks.
// clear restarts the count so a fresh frame is held for a full period.
module lamp_step_div #(
    parameter int DIV_CYCLES = 1,
    parameter int DIV_W      = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    import horse_race_lamp_pkg::*;

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_CYCLES - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/horse_race_lamp.sv
// 8-LED running-lamp pattern generator with four modes selected by S.
// Define HORSE_RACE_LAMP_ACTIVE_LOW_EN to drive Y active-low (0 = lit).
module horse_race_lamp #(
    parameter int DIV_CYCLES = 1,
    parameter int DIV_W      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] S,
    output logic [7:0] Y
);
    import horse_race_lamp_pkg::*;

    mode_e      mode_q;
    step_t      step;
    logic       tick;
    logic       restart;
    logic [7:0] y_q;

    function automatic logic [7:0] drive_level(input logic [7:0] frame);
`ifdef HORSE_RACE_LAMP_ACTIVE_LOW_EN
        return ~frame;
`else
        return frame;
`endif
    endfunction

    assign restart = (mode_e'(S) != mode_q);

    lamp_step_div #(
        .DIV_CYCLES (DIV_CYCLES),
        .DIV_W      (DIV_W)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (restart),
        .tick  (tick)
    );

    // A mode change shows frame 0 immediately and then continues from step 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_LEFT;
            step   <= '0;
            y_q    <= drive_level(8'h00);
        end else if (restart) begin
            mode_q <= mode_e'(S);
            step   <= step_t'(1);
            y_q    <= drive_level(frame_lookup(mode_e'(S), '0));
        end else if (tick) begin
            step   <= next_step(mode_q, step);
            y_q    <= drive_level(frame_lookup(mode_q, step));
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_horse_race_lamp.sv
// Self-checking bench: directed pattern sequences plus randomized mode/reset traffic
// on a DIV_CYCLES=1 and a DIV_CYCLES=4 instance, checked against a table-driven model.
module tb_horse_race_lamp;

    logic       clk = 1'b0;
    logic       rst1, rst4;
    logic [1:0] s1, s4;
    logic [7:0] y1, y4;

    int checks = 0;
    int errors = 0;

    horse_race_lamp #(.DIV_CYCLES(1), .DIV_W(32)) u1 (
        .clk(clk), .reset(rst1), .S(s1), .Y(y1)
    );
    horse_race_lamp #(.DIV_CYCLES(4), .DIV_W(32)) u4 (
        .clk(clk), .reset(rst4), .S(s4), .Y(y4)
    );

    always #5 clk = ~clk;

    logic [7:0] tbl [4][8];
    int         plen [4];
    int         divs [2];
    int         m_mode [2];
    int         m_idx [2];
    int         m_cnt [2];
    logic [7:0] m_y [2];

    function automatic logic [7:0] lamp(input logic [7:0] f);
`ifdef HORSE_RACE_LAMP_ACTIVE_LOW_EN
        return ~f;
`else
        return f;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: frames come from the pattern tables, one per tick.
    task automatic model_edge(input int d, input logic r, input logic [1:0] s);
        if (r) begin
            m_y[d] = 8'h00; m_mode[d] = 0; m_idx[d] = 0; m_cnt[d] = 0;
        end else if (int'(s) != m_mode[d]) begin
            m_mode[d] = int'(s);
            m_y[d]    = tbl[m_mode[d]][0];
            m_idx[d]  = 1 % plen[m_mode[d]];
            m_cnt[d]  = 0;
        end else if (m_cnt[d] == divs[d] - 1) begin
            m_cnt[d] = 0;
            m_y[d]   = tbl[m_mode[d]][m_idx[d]];
            m_idx[d] = (m_idx[d] + 1) % plen[m_mode[d]];
        end else begin
            m_cnt[d] = m_cnt[d] + 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0, rst1, s1);
        model_edge(1, rst4, s4);
        #1;
        chk("model_div1", y1, lamp(m_y[0]));
        chk("model_div4", y4, lamp(m_y[1]));
    endtask

    initial begin
        logic [7:0] lf [8];
        logic [7:0] rt [8];
        logic [7:0] pp [6];
        int k;
        bit found;

        tbl[0] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        tbl[1] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        tbl[2] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h00, 8'h00};
        tbl[3] = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        plen = '{8, 8, 6, 2};
        divs = '{1, 4};
        lf = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        rt = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        pp = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42};
        for (int d = 0; d < 2; d++) begin
            m_y[d] = 8'h00; m_mode[d] = 0; m_idx[d] = 0; m_cnt[d] = 0;
        end

        rst1 = 1'b1; s1 = 2'b00; rst4 = 1'b1; s4 = 2'b00;
        #1;
        cycle();
        chk("reset_y1", y1, lamp(8'h00));
        chk("reset_y4", y4, lamp(8'h00));

        rst1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("left_sweep", y1, lamp(lf[i % 8]));
        end

        rst1 = 1'b1; s1 = 2'b01;
        cycle();
        chk("reset_right", y1, lamp(8'h00));
        rst1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("right_sweep", y1, lamp(rt[i % 8]));
        end

        rst1 = 1'b1; s1 = 2'b10;
        cycle();
        rst1 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            cycle();
            chk("pingpong", y1, lamp(pp[i % 6]));
        end

        rst1 = 1'b1; s1 = 2'b11;
        cycle();
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("flash", y1, lamp((i % 2 == 0) ? 8'h55 : 8'hAA));
        end

        rst1 = 1'b1; s1 = 2'b00;
        cycle();
        rst1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            cycle();
            if (y1 === lamp(8'h10)) found = 1'b1;
        end
        chk("reach_10", {7'd0, found}, 8'h01);
        s1 = 2'b11;
        cycle();
        chk("switch_55", y1, lamp(8'h55));
        cycle();
        chk("switch_aa", y1, lamp(8'hAA));
        s1 = 2'b00;
        cycle();
        chk("back_left", y1, lamp(8'h01));

        // Divided instance: each frame held for four clocks.
        rst4 = 1'b1; s4 = 2'b00;
        cycle();
        rst4 = 1'b0;
        for (k = 1; k <= 20; k++) begin
            cycle();
            chk("div4_hold", y4, lamp((k < 4) ? 8'h00 : lf[(k / 4 - 1) % 8]));
        end
        s4 = 2'b11;
        cycle();
        chk("div4_restart", y4, lamp(8'h55));
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("div4_restart_hold", y4, lamp(8'h55));
        end
        cycle();
        chk("div4_next", y4, lamp(8'hAA));
        cycle();
        rst4 = 1'b1;
        cycle();
        chk("div4_midhold_reset", y4, lamp(8'h00));
        rst4 = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) s1 = 2'($urandom_range(3));
            if ($urandom_range(11) == 0) s4 = 2'($urandom_range(3));
            rst1 = ($urandom_range(63) == 0);
            rst4 = ($urandom_range(63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
